matmul_sequencer: RTL and testbench

Controller that computes a 2x2 single-precision matrix product on one shared floating-point multiplier and one shared floating-point adder. It replaces the eight-multiplier/four-adder fan-out used elsewhere in the coprocessor. The block latches both operand matrices on `start`, issues the eight products and four sums in a fixed order over the units' stb/ack and load/ready/ack handshakes, and registers the four results. A per-transaction watchdog reports a unit that never responds.

---
 rtl/matmul_sequencer_pkg.sv | 48 ++++
 rtl/matmul_sequencer_if.sv | 34 +++
 rtl/matmul_sequencer_watchdog.sv | 31 +++
 rtl/matmul_sequencer.sv | 177 +++++++++++++++++
 tb/tb_matmul_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_sequencer_pkg.sv
// Shared types and constants for the 2x2 matrix-product sequencer.
package matmul_pkg;

    localparam int unsigned FP_W = 32;

    typedef logic [FP_W-1:0] fp_t;

    // Four matrix elements. Index 0..3 maps to 00, 01, 10, 11.
    typedef logic [3:0][FP_W-1:0] mat_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_REQ,
        S_MUL_RSP,
        S_ADD_REQ,
        S_ADD_RSP,
        S_DONE
    } state_t;

    typedef logic [1:0] elem_t;

    localparam elem_t E00 = 2'd0;
    localparam elem_t E01 = 2'd1;
    localparam elem_t E10 = 2'd2;
    localparam elem_t E11 = 2'd3;

    typedef struct packed {
        elem_t a_idx;
        elem_t b_idx;
    } opsel_t;

    // Which A and B elements feed product j of result element e.
    function automatic opsel_t operand_select(input elem_t e, input logic j);
        opsel_t sel;
        case ({e, j})
            3'b000:  sel = '{a_idx: E00, b_idx: E00};
            3'b001:  sel = '{a_idx: E01, b_idx: E10};
            3'b010:  sel = '{a_idx: E00, b_idx: E01};
            3'b011:  sel = '{a_idx: E01, b_idx: E11};
            3'b100:  sel = '{a_idx: E10, b_idx: E00};
            3'b101:  sel = '{a_idx: E11, b_idx: E10};
            3'b110:  sel = '{a_idx: E10, b_idx: E01};
            default: sel = '{a_idx: E11, b_idx: E11};
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Handshake bundle between the sequencer and the shared multiplier/adder.
interface matmul_sequencer_if;
    import matmul_pkg::*;

    fp_t  mul_a;
    fp_t  mul_b;
    logic mul_in_stb;
    logic mul_in_ack;
    fp_t  mul_z;
    logic mul_z_stb;
    logic mul_z_ack;

    fp_t  add_n1;
    fp_t  add_n2;
    logic add_load;
    fp_t  add_result;
    logic add_ready;
    logic add_ack;

    modport master (
        output mul_a, mul_b, mul_in_stb, mul_z_ack,
        output add_n1, add_n2, add_load, add_ack,
        input  mul_in_ack, mul_z, mul_z_stb,
        input  add_result, add_ready
    );

    modport slave (
        input  mul_a, mul_b, mul_in_stb, mul_z_ack,
        input  add_n1, add_n2, add_load, add_ack,
        output mul_in_ack, mul_z, mul_z_stb,
        output add_result, add_ready
    );

endinterface

// File: rtl/matmul_sequencer_watchdog.sv
// Per-state cycle counter; flags a wait that has lasted TIMEOUT cycles (0 disables).
module handshake_watchdog
    import matmul_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // count holds cycles spent in the current state minus the first one; clear marks that first cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= CW'(1);
        end else if (count != LIMIT) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && !clear && (count == LIMIT);

endmodule

// File: rtl/matmul_sequencer.sv
// 2x2 single-precision matrix product sequenced over one shared multiplier and one shared adder.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  fp_t  matrix_one_00,
    input  fp_t  matrix_one_01,
    input  fp_t  matrix_one_10,
    input  fp_t  matrix_one_11,
    input  fp_t  matrix_two_00,
    input  fp_t  matrix_two_01,
    input  fp_t  matrix_two_10,
    input  fp_t  matrix_two_11,
    output logic busy,
    output logic done,
    output logic error,
    output fp_t  result_00,
    output fp_t  result_01,
    output fp_t  result_10,
    output fp_t  result_11,
    matmul_sequencer_if.master units
);

    state_t state;
    state_t state_prev;
    elem_t  elem;
    logic   prod_sel;
    fp_t    prod_0;
    mat_t   op_a;
    mat_t   op_b;
    mat_t   res;
    mat_t   in_a;
    mat_t   in_b;
    opsel_t sel_first;
    opsel_t sel_j1;
    opsel_t sel_next;
    logic   wd_clear;
    logic   wd_expired;

    assign in_a = {matrix_one_11, matrix_one_10, matrix_one_01, matrix_one_00};
    assign in_b = {matrix_two_11, matrix_two_10, matrix_two_01, matrix_two_00};

    assign sel_first = operand_select(E00, 1'b0);
    assign sel_j1    = operand_select(elem, 1'b1);
    assign sel_next  = operand_select(elem + 2'd1, 1'b0);

    assign wd_clear = (state != state_prev);

    handshake_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .expired (wd_expired)
    );

    assign units.mul_z_ack = (state == S_MUL_RSP) && units.mul_z_stb;
    assign units.add_ack   = (state == S_ADD_RSP) && units.add_ready;

    assign result_00 = res[0];
    assign result_01 = res[1];
    assign result_10 = res[2];
    assign result_11 = res[3];

    // Sequencer: issues the eight products and four sums in order and owns every registered output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            state_prev       <= S_IDLE;
            elem             <= E00;
            prod_sel         <= 1'b0;
            prod_0           <= '0;
            op_a             <= '0;
            op_b             <= '0;
            res              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            units.mul_a      <= '0;
            units.mul_b      <= '0;
            units.mul_in_stb <= 1'b0;
            units.add_n1     <= '0;
            units.add_n2     <= '0;
            units.add_load   <= 1'b0;
        end else begin
            state_prev <= state;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_a             <= in_a;
                        op_b             <= in_b;
                        error            <= 1'b0;
                        elem             <= E00;
                        prod_sel         <= 1'b0;
                        units.mul_a      <= in_a[sel_first.a_idx];
                        units.mul_b      <= in_b[sel_first.b_idx];
                        units.mul_in_stb <= 1'b1;
                        busy             <= 1'b1;
                        state            <= S_MUL_REQ;
                    end
                end
                S_MUL_REQ: begin
                    if (units.mul_in_ack) begin
                        units.mul_in_stb <= 1'b0;
                        state            <= S_MUL_RSP;
                    end else if (wd_expired) begin
                        units.mul_in_stb <= 1'b0;
                        error            <= 1'b1;
                        done             <= 1'b1;
                        state            <= S_DONE;
                    end
                end
                S_MUL_RSP: begin
                    if (units.mul_z_stb) begin
                        if (!prod_sel) begin
                            prod_0           <= units.mul_z;
                            prod_sel         <= 1'b1;
                            units.mul_a      <= op_a[sel_j1.a_idx];
                            units.mul_b      <= op_b[sel_j1.b_idx];
                            units.mul_in_stb <= 1'b1;
                            state            <= S_MUL_REQ;
                        end else begin
                            // Second product goes straight into the adder operand register;
                            // add_n2 then holds it until the sum is accepted.
                            units.add_n1   <= prod_0;
                            units.add_n2   <= units.mul_z;
                            units.add_load <= 1'b1;
                            state          <= S_ADD_REQ;
                        end
                    end else if (wd_expired) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_ADD_REQ: begin
                    units.add_load <= 1'b0;
                    state          <= S_ADD_RSP;
                end
                S_ADD_RSP: begin
                    if (units.add_ready) begin
                        res[elem] <= units.add_result;
                        if (elem == E11) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            elem             <= elem + 2'd1;
                            prod_sel         <= 1'b0;
                            units.mul_a      <= op_a[sel_next.a_idx];
                            units.mul_b      <= op_b[sel_next.b_idx];
                            units.mul_in_stb <= 1'b1;
                            state            <= S_MUL_REQ;
                        end
                    end else if (wd_expired) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with behavioural zero-wait multiplier and adder.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    localparam int unsigned MODE_PLAIN = 0;
    localparam int unsigned MODE_STALL = 1;
    localparam int unsigned MODE_START = 2;
    localparam int unsigned MODE_RESET = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] m1 [4];
    logic [31:0] m2 [4];
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] r00;
    logic [31:0] r01;
    logic [31:0] r10;
    logic [31:0] r11;

    logic        stall_mul = 1'b0;
    logic        add_dead  = 1'b0;
    logic [31:0] mz;
    logic        mz_stb;
    logic [31:0] ares;
    logic        ar;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    matmul_sequencer_if units ();

    matmul_sequencer #(
        .TIMEOUT(16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .matrix_one_00 (m1[0]),
        .matrix_one_01 (m1[1]),
        .matrix_one_10 (m1[2]),
        .matrix_one_11 (m1[3]),
        .matrix_two_00 (m2[0]),
        .matrix_two_01 (m2[1]),
        .matrix_two_10 (m2[2]),
        .matrix_two_11 (m2[3]),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .result_00     (r00),
        .result_01     (r01),
        .result_10     (r10),
        .result_11     (r11),
        .units         (units)
    );

    always #5 clock = ~clock;

    // Stand-in arithmetic: exact for operands of 0 and 1.0, a recognisable tag otherwise.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return 32'h0000_0000;
        if (a == 32'h3F80_0000) return b;
        if (b == 32'h3F80_0000) return a;
        return a ^ b ^ 32'hDEAD_0000;
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0) return b;
        if (b[30:0] == 31'd0) return a;
        return a ^ b ^ 32'h0000_5A5A;
    endfunction

    assign units.mul_in_ack = units.mul_in_stb && !stall_mul;
    assign units.mul_z      = mz;
    assign units.mul_z_stb  = mz_stb;
    assign units.add_result = ares;
    assign units.add_ready  = ar;

    always @(posedge clock) begin
        if (reset) begin
            mz_stb <= 1'b0;
            mz     <= '0;
        end else if (mz_stb && units.mul_z_ack) begin
            mz_stb <= 1'b0;
        end else if (units.mul_in_stb && units.mul_in_ack) begin
            mz     <= fmul(units.mul_a, units.mul_b);
            mz_stb <= 1'b1;
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            ar   <= 1'b0;
            ares <= '0;
        end else if (ar && units.add_ack) begin
            ar <= 1'b0;
        end else if (units.add_load && !add_dead) begin
            ares <= fadd(units.add_n1, units.add_n2);
            ar   <= 1'b1;
        end
    end

    logic [31:0] mul_log_a [$];
    logic [31:0] mul_log_b [$];
    logic [31:0] add_log_1 [$];
    logic [31:0] add_log_2 [$];
    int unsigned stb_rises   = 0;
    int unsigned load_cycles = 0;
    int unsigned done_pulses = 0;
    logic        prev_stb    = 1'b0;
    logic        prev_done   = 1'b0;

    always @(negedge clock) begin
        #1;
        if (units.mul_in_stb && units.mul_in_ack) begin
            mul_log_a.push_back(units.mul_a);
            mul_log_b.push_back(units.mul_b);
        end
        if (units.add_load) begin
            add_log_1.push_back(units.add_n1);
            add_log_2.push_back(units.add_n2);
            load_cycles <= load_cycles + 1;
        end
        if (units.mul_in_stb && !prev_stb) stb_rises <= stb_rises + 1;
        if (done && !prev_done) done_pulses <= done_pulses + 1;
        prev_stb  <= units.mul_in_stb;
        prev_done <= done;
    end

    logic [31:0] exp_mul_a [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000,
                                   32'h4040_0000, 32'h4080_0000, 32'h4040_0000, 32'h4080_0000};
    logic [31:0] exp_mul_b [8] = '{32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000,
                                   32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000};
    logic [31:0] exp_add_1 [4] = '{32'h3F80_0000, 32'h0000_0000, 32'h4040_0000, 32'h0000_0000};
    logic [31:0] exp_add_2 [4] = '{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 32'h4080_0000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic load_identity_case();
        m1 = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        m2 = '{32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000};
    endtask

    task automatic check_results(input string pfx, input logic [31:0] e0, input logic [31:0] e1,
                                 input logic [31:0] e2, input logic [31:0] e3);
        check({pfx, "_result_00"}, r00, e0);
        check({pfx, "_result_01"}, r01, e1);
        check({pfx, "_result_10"}, r10, e2);
        check({pfx, "_result_11"}, r11, e3);
    endtask

    task automatic check_sequence(input string pfx, input int unsigned base_m, input int unsigned base_l,
                                  input int unsigned base_s, input int unsigned base_c);
        check({pfx, "_mul_handshakes"}, mul_log_a.size() - base_m, 8);
        check({pfx, "_stb_assertions"}, stb_rises - base_s, 8);
        check({pfx, "_add_load_cycles"}, load_cycles - base_c, 4);
        if (mul_log_a.size() >= base_m + 8) begin
            for (int unsigned k = 0; k < 8; k++) begin
                check($sformatf("%s_mul_a_%0d", pfx, k), mul_log_a[base_m + k], exp_mul_a[k]);
                check($sformatf("%s_mul_b_%0d", pfx, k), mul_log_b[base_m + k], exp_mul_b[k]);
            end
        end
        if (add_log_1.size() >= base_l + 4) begin
            for (int unsigned k = 0; k < 4; k++) begin
                check($sformatf("%s_add_n1_%0d", pfx, k), add_log_1[base_l + k], exp_add_1[k]);
                check($sformatf("%s_add_n2_%0d", pfx, k), add_log_2[base_l + k], exp_add_2[k]);
            end
        end
    endtask

    // Cycle c is the c-th cycle after the edge that samples start; returns the cycle done was seen in.
    task automatic run_op(input int unsigned mode, output int unsigned done_c);
        done_c = 0;
        @(negedge clock);
        start = 1'b1;
        for (int unsigned c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (c == 1) begin
                start = 1'b0;
                check("busy_after_start", busy, 1);
                check("error_clear_after_start", error, 0);
            end
            if (mode == MODE_STALL) begin
                stall_mul = (c >= 6 && c <= 16);
                if (c >= 7 && c <= 17) begin
                    check($sformatf("stall_stb_c%0d", c), units.mul_in_stb, 1);
                    check($sformatf("stall_mul_a_c%0d", c), units.mul_a, 32'h3F80_0000);
                    check($sformatf("stall_mul_b_c%0d", c), units.mul_b, 32'h0000_0000);
                end
                if (c == 18) check("stall_stb_drop", units.mul_in_stb, 0);
            end
            if (mode == MODE_START) begin
                if (c == 5) begin
                    start = 1'b1;
                    m1 = '{32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000};
                    m2 = '{32'h4140_0000, 32'h4150_0000, 32'h4160_0000, 32'h4170_0000};
                end
                if (c == 6) begin
                    start = 1'b0;
                    load_identity_case();
                end
            end
            if (mode == MODE_RESET) begin
                if (c == 12) reset = 1'b1;
                if (c == 13) begin
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_error", error, 0);
                    check("rst_mul_in_stb", units.mul_in_stb, 0);
                    check("rst_mul_z_ack", units.mul_z_ack, 0);
                    check("rst_add_load", units.add_load, 0);
                    check("rst_add_ack", units.add_ack, 0);
                    check("rst_mul_a", units.mul_a, 0);
                    check("rst_mul_b", units.mul_b, 0);
                    check("rst_add_n1", units.add_n1, 0);
                    check("rst_add_n2", units.add_n2, 0);
                    check_results("rst", 0, 0, 0, 0);
                    reset = 1'b0;
                    return;
                end
            end
            if (done) begin
                done_c = c;
                break;
            end
        end
        if (done_c != 0) begin
            @(negedge clock);
            check("done_single_cycle", done, 0);
            check("busy_low_after_done", busy, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int unsigned dc;
        int unsigned bm, bl, bs, bc, bd;

        reset = 1'b1;
        start = 1'b0;
        load_identity_case();
        repeat (3) @(negedge clock);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_mul_in_stb", units.mul_in_stb, 0);
        check("reset_add_load", units.add_load, 0);
        check("reset_mul_a", units.mul_a, 0);
        check("reset_add_n1", units.add_n1, 0);
        check_results("reset", 0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clock);

        // Zero-wait units, A=[1,2;3,4], B=identity.
        bm = mul_log_a.size(); bl = add_log_1.size(); bs = stb_rises; bc = load_cycles;
        run_op(MODE_PLAIN, dc);
        check("t1_done_cycle", dc, 25);
        check_results("t1", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        check_sequence("t1", bm, bl, bs, bc);

        // Multiplier withholds ack for 10 cycles on the third request.
        repeat (2) @(negedge clock);
        bm = mul_log_a.size(); bl = add_log_1.size(); bs = stb_rises; bc = load_cycles;
        run_op(MODE_STALL, dc);
        stall_mul = 1'b0;
        check("t2_done_cycle", dc, 35);
        check_results("t2", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        check_sequence("t2", bm, bl, bs, bc);

        // Adder never responds: watchdog abort 17 cycles after entering ADD_RSP of element 00.
        repeat (2) @(negedge clock);
        add_dead = 1'b1;
        run_op(MODE_PLAIN, dc);
        check("t3_done_cycle", dc, 23);
        check("t3_error_set", error, 1);
        check_results("t3", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        add_dead = 1'b0;

        // start re-pulsed mid-operation with other operands is ignored.
        repeat (2) @(negedge clock);
        run_op(MODE_START, dc);
        check("t4_done_cycle", dc, 25);
        check("t4_error", error, 0);
        check_results("t4", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);

        // Reset in cycle 12, no done pulse, then a clean operation.
        repeat (2) @(negedge clock);
        bd = done_pulses;
        run_op(MODE_RESET, dc);
        repeat (8) @(negedge clock);
        check("t5_no_done_pulse", done_pulses - bd, 0);
        check("t5_idle_busy", busy, 0);
        run_op(MODE_PLAIN, dc);
        check("t5_done_cycle", dc, 25);
        check_results("t5", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
